// File: rtl/batch_normalization_pipelined.sv
// Per-channel batch-normalization step: out_u = sat(u + addend[ch] + factor[ch]*z).
// One shared 2-stage valid/ready datapath serves N_CHANNELS time-multiplexed neurons.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   cfg_we/ch/factor/addend  per-channel config write; cfg_err pulses on an illegal factor code
//   in_valid/ready/ch/u/z    sample input handshake
//   out_valid/ready/ch/u/sat result output handshake; out_sat flags a clamped result

// One channel's factor/addend register pair.
module bn_chan_cfg #(
    parameter int ADDEND_WIDTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           we,
    input  logic [3:0]                     wr_factor,
    input  logic signed [ADDEND_WIDTH-1:0] wr_addend,
    output logic [3:0]                     factor,
    output logic signed [ADDEND_WIDTH-1:0] addend
);
    always_ff @(posedge clk) begin
        if (reset) begin
            factor <= 4'b0100;  // x1
            addend <= '0;
        end else if (we) begin
            factor <= wr_factor;
            addend <= wr_addend;
        end
    end
endmodule

module batch_normalization_pipelined #(
    parameter int WIDTH        = 6,
    parameter int ADDEND_WIDTH = WIDTH - 2,
    parameter int N_CHANNELS   = 4,
    localparam int CH_W        = $clog2(N_CHANNELS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_we,
    input  logic [CH_W-1:0]                cfg_ch,
    input  logic [3:0]                     cfg_factor,
    input  logic signed [ADDEND_WIDTH-1:0] cfg_addend,
    output logic                           cfg_err,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CH_W-1:0]                in_ch,
    input  logic signed [WIDTH-1:0]        in_u,
    input  logic signed [WIDTH-1:0]        in_z,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CH_W-1:0]                out_ch,
    output logic signed [WIDTH-1:0]        out_u,
    output logic                           out_sat
);
    // WIDTH+5 covers u + addend + (z<<2) + (z<<3) without wrap.
    localparam int IW     = WIDTH + 5;
    localparam int STAGES = 2;
    localparam logic signed [IW-1:0] SAT_MAX = IW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [IW-1:0] SAT_MIN = IW'(-(1 << (WIDTH - 1)));

    logic [STAGES:1] vld_pipe;  // [1] stage-1 register, [2] output register
    logic            stall, advance, accept, cfg_legal;

    assign out_valid = vld_pipe[2];
    assign stall     = out_valid & ~out_ready;
    assign advance   = ~stall;
    assign in_ready  = ~stall;
    assign accept    = in_valid & in_ready;

    // Term B = z<<3 only pairs with term A = 0; other x11 codes are rejected.
    assign cfg_legal = ~((cfg_factor[1:0] == 2'b11) && (cfg_factor[3:2] != 2'b00));

    // ---------------- per-channel configuration ----------------
    logic [N_CHANNELS-1:0][3:0]              ch_factor;
    logic [N_CHANNELS-1:0][ADDEND_WIDTH-1:0] ch_addend;

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        logic we_g;
        logic signed [ADDEND_WIDTH-1:0] addend_g;
        assign we_g = cfg_we & cfg_legal & (cfg_ch == CH_W'(g));
        bn_chan_cfg #(.ADDEND_WIDTH(ADDEND_WIDTH)) u_cfg (
            .clk       (clk),
            .reset     (reset),
            .we        (we_g),
            .wr_factor (cfg_factor),
            .wr_addend (cfg_addend),
            .factor    (ch_factor[g]),
            .addend    (addend_g)
        );
        assign ch_addend[g] = addend_g;
    end

    // ---------------- stage 1 combinational ----------------
    // Reads the registers before this edge's write lands, so a same-cycle
    // write on the same channel is seen only by later samples.
    logic [3:0]              sel_factor;
    logic [ADDEND_WIDTH-1:0] sel_addend;
    logic signed [IW-1:0]    z_ext, base_c, term_a_c, term_b_c;

    assign sel_factor = ch_factor[in_ch];
    assign sel_addend = ch_addend[in_ch];
    assign z_ext      = {{(IW-WIDTH){in_z[WIDTH-1]}}, in_z};
    assign base_c     = {{(IW-WIDTH){in_u[WIDTH-1]}}, in_u}
                      + {{(IW-ADDEND_WIDTH){sel_addend[ADDEND_WIDTH-1]}}, sel_addend};

    always_comb begin
        term_a_c = '0;
        case (sel_factor[3:2])
            2'b01:   term_a_c = z_ext;
            2'b10:   term_a_c = z_ext >>> 2;
            2'b11:   term_a_c = z_ext <<< 2;
            default: term_a_c = '0;
        endcase
    end

    always_comb begin
        term_b_c = '0;
        case (sel_factor[1:0])
            2'b01:   term_b_c = z_ext >>> 1;
            2'b10:   term_b_c = z_ext <<< 1;
            2'b11:   term_b_c = z_ext <<< 3;
            default: term_b_c = '0;
        endcase
    end

    // ---------------- stage 2 combinational ----------------
    logic [CH_W-1:0]         s1_ch;
    logic signed [IW-1:0]    s1_base, s1_a, s1_b, sum;
    logic signed [WIDTH-1:0] sat_u;
    logic                    sat_c;

    assign sum = s1_base + s1_a + s1_b;

    always_comb begin
        sat_u = sum[WIDTH-1:0];
        sat_c = 1'b0;
        if (sum > SAT_MAX) begin
            sat_u = {1'b0, {(WIDTH-1){1'b1}}};
            sat_c = 1'b1;
        end else if (sum < SAT_MIN) begin
            sat_u = {1'b1, {(WIDTH-1){1'b0}}};
            sat_c = 1'b1;
        end
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_ch    <= '0;
            s1_base  <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            out_ch   <= '0;
            out_u    <= '0;
            out_sat  <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~cfg_legal;
            // Whole pipe freezes while the output is held by backpressure.
            if (advance) begin
                vld_pipe <= {vld_pipe[1], accept};
                if (accept) begin
                    s1_ch   <= in_ch;
                    s1_base <= base_c;
                    s1_a    <= term_a_c;
                    s1_b    <= term_b_c;
                end
                if (vld_pipe[1]) begin
                    out_ch  <= s1_ch;
                    out_u   <= sat_u;
                    out_sat <= sat_c;
                end
            end
        end
    end
endmodule
